// File: rtl/reg_result_reader_pkg.sv
// Shared types and constants for the regression result reader.
// Frame layout constants and FSM encoding live here so the bench can use them too.
package reg_result_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   localparam int          FRAME_LEN  = 6;
   localparam int          IDX_W      = 3;
   localparam logic [7:0]  HEADER_DEF = 8'hA5;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

endpackage : reg_result_pkg

// File: rtl/reg_result_reader_if.sv
// Byte-wide valid/ready stream from the result reader to the host-link byte consumer.
// master drives data/valid, slave drives ready.
interface reg_result_reader_if;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);
endinterface : reg_result_reader_if

// File: rtl/reg_result_reader.sv
// Captures b0/b1 when done sets and ships them as a 6-byte checksummed frame.
// Latency: first byte valid one cycle after done is seen; bytes held stable under backpressure.
module reg_result_reader
   import reg_result_pkg::*;
#(
   parameter int         COEF_W = 14,          // 9..16
   parameter logic [7:0] HEADER = HEADER_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 done_i,
   input  logic [COEF_W-1:0]    b0_i,
   input  logic [COEF_W-1:0]    b1_i,
   reg_result_reader_if.master  tx,
   output logic                 flag_clr_o,
   output logic                 busy_o
);

   state_t             state_q;
   logic [IDX_W-1:0]   idx_q;
   logic [7:0]         chk_q;
   logic [7:0]         data_q;
   logic               vld_q;
   logic               clr_q;
   logic               busy_q;
   logic [COEF_W-1:0]  b0_q;
   logic [COEF_W-1:0]  b1_q;

   logic [15:0]        b0_ext;
   logic [15:0]        b1_ext;
   logic [IDX_W-1:0]   idx_d;
   logic [7:0]         byte_d;

   assign b0_ext = 16'(b0_q);
   assign b1_ext = 16'(b1_q);
   assign idx_d  = idx_q + 1'b1;

   // Byte that becomes current after the present one is accepted.
   always_comb begin
      byte_d = HEADER;
      case (idx_d)
         3'd1:    byte_d = b0_ext[15:8];
         3'd2:    byte_d = b0_ext[7:0];
         3'd3:    byte_d = b1_ext[15:8];
         3'd4:    byte_d = b1_ext[7:0];
         3'd5:    byte_d = chk_q;
         default: byte_d = HEADER;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         chk_q   <= 8'h00;
         data_q  <= 8'h00;
         vld_q   <= 1'b0;
         clr_q   <= 1'b0;
         busy_q  <= 1'b0;
         b0_q    <= '0;
         b1_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (done_i) begin
                  b0_q    <= b0_i;
                  b1_q    <= b1_i;
                  idx_q   <= '0;
                  data_q  <= HEADER;
                  vld_q   <= 1'b1;
                  busy_q  <= 1'b1;
                  chk_q   <= HEADER;
                  state_q <= SEND;
               end
            end
            SEND: begin
               if (vld_q && tx.out_ready) begin
                  if (idx_q == LAST_IDX) begin
                     vld_q   <= 1'b0;
                     clr_q   <= 1'b1;
                     state_q <= ACK;
                  end else begin
                     idx_q  <= idx_d;
                     data_q <= byte_d;
                     // The checksum byte itself is not folded back into the accumulator.
                     if (idx_d != LAST_IDX) begin
                        chk_q <= chk_q ^ byte_d;
                     end
                  end
               end
            end
            ACK: begin
               clr_q   <= 1'b0;
               busy_q  <= 1'b0;
               idx_q   <= '0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign tx.out_data  = data_q;
   assign tx.out_valid = vld_q;
   assign flag_clr_o   = clr_q;
   assign busy_o       = busy_q;

endmodule : reg_result_reader

// File: tb/tb_reg_result_reader.sv
// Bench for reg_result_reader: table-driven frames with a byte scoreboard and a model of the done flag register.
module tb_reg_result_reader;
   import reg_result_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flag = 1'b0;
   logic        flag_set = 1'b0;
   logic [13:0] b0 = '0;
   logic [13:0] b1 = '0;
   logic        flag_clr;
   logic        busy;
   int          rmode = 0;
   int          rpat = 0;
   int          checks = 0;
   int          errors = 0;
   int          clr_cnt = 0;
   int          clr_base = 0;
   int          rx_idx = 0;
   logic [7:0]  exp_q[$];

   reg_result_reader_if tx();

   reg_result_reader #(.COEF_W(14), .HEADER(8'hA5)) dut (
      .clk       (clk),
      .rst       (rst),
      .done_i    (flag),
      .b0_i      (b0),
      .b1_i      (b1),
      .tx        (tx),
      .flag_clr_o(flag_clr),
      .busy_o    (busy)
   );

   always #5 clk = ~clk;

   // Done flag register: cleared by flag_clr (priority), set by the bench; unaffected by rst.
   always @(posedge clk) begin
      if (flag_clr) flag <= 1'b0;
      else if (flag_set) flag <= 1'b1;
   end

   always @(posedge clk) begin
      #1;
      case (rmode)
         0: tx.out_ready = 1'b1;
         1: begin
            tx.out_ready = (rpat == 0);
            rpat = (rpat + 1) % 3;
         end
         default: tx.out_ready = 1'($urandom_range(0, 1));
      endcase
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      checks++;
      errors++;
      $display("FAIL %s: bound expired", nm);
   endtask

   function automatic logic [47:0] model(input logic [13:0] v0, input logic [13:0] v1);
      logic [7:0] h0, l0, h1, l1;
      h0 = {2'b00, v0[13:8]};
      l0 = v0[7:0];
      h1 = {2'b00, v1[13:8]};
      l1 = v1[7:0];
      return {8'hA5, h0, l0, h1, l1, 8'hA5 ^ h0 ^ l0 ^ h1 ^ l1};
   endfunction

   // Scoreboard/protocol monitor: a byte seen valid&ready here is accepted at the next posedge.
   logic       prev_stall = 1'b0;
   logic       prev_last = 1'b0;
   logic       prev_clr = 1'b0;
   logic [7:0] prev_data = 8'h00;
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         rx_idx     = 0;
         prev_stall = 1'b0;
         prev_last  = 1'b0;
         prev_clr   = 1'b0;
      end else begin
         if (prev_stall) chk("stall_hold", {tx.out_valid, tx.out_data}, {1'b1, prev_data});
         if (prev_last)  chk("flag_clr_after_last", flag_clr, 1);
         if (prev_clr)   chk("busy_drop_after_clr", {busy, flag_clr}, 0);
         if (flag_clr) clr_cnt++;
         prev_last = 1'b0;
         if (tx.out_valid && tx.out_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %0h expected none", tx.out_data);
            end else begin
               chk($sformatf("byte%0d", rx_idx), tx.out_data, exp_q.pop_front());
            end
            prev_last = (rx_idx == 5);
            rx_idx = (rx_idx == 5) ? 0 : rx_idx + 1;
         end
         prev_stall = tx.out_valid && !tx.out_ready;
         prev_data  = tx.out_data;
         prev_clr   = flag_clr;
      end
   end

   task automatic push_frame(input logic [47:0] e);
      for (int i = 5; i >= 0; i--) exp_q.push_back(e[i*8 +: 8]);
   endtask

   task automatic start_frame(input logic [13:0] v0, input logic [13:0] v1, input logic [47:0] e);
      int n;
      n = 0;
      while ((busy || flag) && n < 200) begin
         @(posedge clk);
         n++;
      end
      if (n >= 200) fail_now("wait_idle");
      @(posedge clk);
      #1;
      b0 = v0;
      b1 = v1;
      clr_base = clr_cnt;
      push_frame(e);
      flag_set = 1'b1;
      @(posedge clk);
      #1;
      flag_set = 1'b0;
      @(negedge clk);
      chk("pre_capture_valid", tx.out_valid, 0);
      @(negedge clk);
      chk("capture_latency", {tx.out_valid, busy, tx.out_data}, {1'b1, 1'b1, 8'hA5});
   endtask

   task automatic wait_done();
      int n;
      n = 0;
      while (flag && n < 400) begin
         @(posedge clk);
         n++;
      end
      if (n >= 400) fail_now("wait_flag_clear");
      repeat (4) @(negedge clk);
      chk("frame_drained", exp_q.size(), 0);
      chk("one_flag_clr", clr_cnt - clr_base, 1);
      chk("idle_after_frame", {busy, tx.out_valid}, 0);
   endtask

   typedef struct {
      logic [13:0] v0;
      logic [13:0] v1;
      int          mode;
      logic [47:0] exp;
   } vec_t;

   vec_t tbl[5];

   initial begin
      tbl[0] = '{14'h1234, 14'h0ABC, 0, 48'hA5_12_34_0A_BC_35};
      tbl[1] = '{14'h1234, 14'h0ABC, 1, 48'hA5_12_34_0A_BC_35};
      tbl[2] = '{14'h0000, 14'h0000, 0, 48'hA5_00_00_00_00_A5};
      tbl[3] = '{14'h3FFF, 14'h3FFF, 2, 48'hA5_3F_FF_3F_FF_A5};
      tbl[4] = '{14'h2001, 14'h1F80, 1, 48'hA5_20_01_1F_80_1B};

      tx.out_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {tx.out_data, tx.out_valid, flag_clr, busy}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         rmode = tbl[i].mode;
         start_frame(tbl[i].v0, tbl[i].v1, tbl[i].exp);
         wait_done();
      end

      // Capture isolation: b0 changes mid-frame, next frame picks up the new value.
      rmode = 1;
      start_frame(14'h1234, 14'h0ABC, 48'hA5_12_34_0A_BC_35);
      b0 = 14'h3FFF;
      wait_done();
      start_frame(14'h3FFF, 14'h0ABC, 48'hA5_3F_FF_0A_BC_D3);
      wait_done();

      // Reset after byte 2 is accepted: frame abandoned, restarts from header.
      rmode = 0;
      start_frame(14'h1234, 14'h0ABC, 48'hA5_12_34_0A_BC_35);
      begin
         int n;
         n = 0;
         while (rx_idx != 3 && n < 50) begin
            @(posedge clk);
            n++;
         end
         if (n >= 50) fail_now("wait_byte2");
      end
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      push_frame(48'hA5_12_34_0A_BC_35);
      @(negedge clk);
      chk("rst_abandon", {tx.out_valid, busy, flag_clr}, 0);
      chk("rst_flag_kept", flag, 1);
      chk("rst_no_clr", clr_cnt - clr_base, 0);
      @(negedge clk);
      chk("restart_header", {tx.out_valid, tx.out_data}, {1'b1, 8'hA5});
      wait_done();

      // Random coefficients under random backpressure.
      rmode = 2;
      for (int i = 0; i < 4; i++) begin
         logic [13:0] r0, r1;
         r0 = 14'($urandom);
         r1 = 14'($urandom);
         start_frame(r0, r1, model(r0, r1));
         wait_done();
      end

      // No spurious frame while done stays low.
      repeat (20) @(negedge clk);
      chk("quiet_idle", {busy, tx.out_valid, flag_clr}, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_reg_result_reader
